// File: rtl/adsr_envelope.sv
// Gate-triggered ADSR envelope generator producing a unipolar gain CV, its negation,
// the gate state and an end-of-cycle trigger, all updated on the sample-rate strobe.
module adsr_envelope #(
    parameter int W         = 16,
    parameter int GATE_ON   = 4000,
    parameter int GATE_OFF  = 2000,
    parameter int TRIG_LVL  = 20000,
    parameter int EOC_TICKS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_clk,
    input  logic signed [W-1:0] sample_in0,
    input  logic signed [W-1:0] sample_in1,
    input  logic signed [W-1:0] sample_in2,
    input  logic signed [W-1:0] sample_in3,
    output logic signed [W-1:0] sample_out0,
    output logic signed [W-1:0] sample_out1,
    output logic signed [W-1:0] sample_out2,
    output logic signed [W-1:0] sample_out3,
    input  logic [7:0]          jack
);
    localparam int AW = W + 7;
    localparam int EW = $clog2(EOC_TICKS + 1);
    localparam logic [AW-1:0]       FS      = {AW{1'b1}};
    localparam logic signed [W-1:0] ON_LVL  = GATE_ON[W-1:0];
    localparam logic signed [W-1:0] OFF_LVL = GATE_OFF[W-1:0];
    localparam logic signed [W-1:0] TRIG    = TRIG_LVL[W-1:0];
    localparam logic [EW-1:0]       EOC_INIT = EOC_TICKS[EW-1:0];

    typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;

    // Negative CVs clamp to zero; positive ones drop the sign bit.
    function automatic logic [W-2:0] pos(input logic signed [W-1:0] x);
        return x[W-1] ? {(W-1){1'b0}} : x[W-2:0];
    endfunction

    state_t              state_r, state_s;
    logic [AW-1:0]       env_r, env_s;
    logic                gate_r, gate_s, sclk_q_r, tick_s, rise_s, fall_s;
    logic [EW-1:0]       eoc_r, eoc_s;
    logic [W-1:0]        atk_s, dr_s;
    logic [AW-1:0]       sus_s;
    logic [AW:0]         sum_s;
    logic signed [W-1:0] out0_s, out1_s, out2_s, out3_s;
    logic signed [W-1:0] out0_r, out1_r, out2_r, out3_r;
    logic                unused_jack;

    assign unused_jack = ^jack;
    assign tick_s = sample_clk & ~sclk_q_r;
    assign atk_s  = {1'b0, pos(sample_in1)} + {{(W-1){1'b0}}, 1'b1};
    assign dr_s   = {1'b0, pos(sample_in2)} + {{(W-1){1'b0}}, 1'b1};
    assign sus_s  = {pos(sample_in3), 8'h00};
    assign sum_s  = {1'b0, env_r} + {{(AW+1-W){1'b0}}, atk_s};

    // State, accumulator, gate, EOC counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            env_r    <= {AW{1'b0}};
            gate_r   <= 1'b0;
            eoc_r    <= {EW{1'b0}};
            sclk_q_r <= 1'b0;
            out0_r   <= {W{1'b0}};
            out1_r   <= {W{1'b0}};
            out2_r   <= {W{1'b0}};
            out3_r   <= {W{1'b0}};
        end else begin
            state_r  <= state_s;
            env_r    <= env_s;
            gate_r   <= gate_s;
            eoc_r    <= eoc_s;
            sclk_q_r <= sample_clk;
            out0_r   <= out0_s;
            out1_r   <= out1_s;
            out2_r   <= out2_s;
            out3_r   <= out3_s;
        end
    end

    // Next state: gate edges pre-empt rate progression and consume the tick.
    always_comb begin
        state_s = state_r;
        env_s   = env_r;
        gate_s  = gate_r;
        eoc_s   = eoc_r;
        rise_s  = 1'b0;
        fall_s  = 1'b0;
        if (tick_s) begin
            if (sample_in0 > ON_LVL)        gate_s = 1'b1;
            else if (sample_in0 < OFF_LVL)  gate_s = 1'b0;
            else                            gate_s = gate_r;
            rise_s = gate_s & ~gate_r;
            fall_s = ~gate_s & gate_r;
            if (eoc_r != {EW{1'b0}}) eoc_s = eoc_r - {{(EW-1){1'b0}}, 1'b1};
            else                     eoc_s = eoc_r;
            if (rise_s) begin
                state_s = ATTACK;
                eoc_s   = {EW{1'b0}};
            end else if (fall_s && (state_r == ATTACK || state_r == DECAY || state_r == SUSTAIN)) begin
                state_s = RELEASE;
            end else begin
                case (state_r)
                    ATTACK: begin
                        if (sum_s >= {1'b0, FS}) begin
                            env_s   = FS;
                            state_s = DECAY;
                        end else begin
                            env_s = sum_s[AW-1:0];
                        end
                    end
                    DECAY: begin
                        if ({1'b0, env_r} <= {1'b0, sus_s} + {{(AW+1-W){1'b0}}, dr_s}) begin
                            env_s   = sus_s;
                            state_s = SUSTAIN;
                        end else begin
                            env_s = env_r - {{(AW-W){1'b0}}, dr_s};
                        end
                    end
                    SUSTAIN: env_s = sus_s;
                    RELEASE: begin
                        if (env_r <= {{(AW-W){1'b0}}, dr_s}) begin
                            env_s   = {AW{1'b0}};
                            state_s = IDLE;
                            eoc_s   = EOC_INIT;
                        end else begin
                            env_s = env_r - {{(AW-W){1'b0}}, dr_s};
                        end
                    end
                    IDLE:    env_s = {AW{1'b0}};
                    default: begin
                        env_s   = {AW{1'b0}};
                        state_s = IDLE;
                    end
                endcase
            end
        end else begin
            state_s = state_r;
        end
    end

    // Output decode from the current registered state.
    always_comb begin
        out0_s = {1'b0, env_r[AW-1:8]};
        out1_s = {W{1'b0}} - out0_s;
        if (gate_r) out2_s = TRIG;
        else        out2_s = {W{1'b0}};
        if (eoc_r != {EW{1'b0}}) out3_s = TRIG;
        else                     out3_s = {W{1'b0}};
    end

    assign sample_out0 = out0_r;
    assign sample_out1 = out1_r;
    assign sample_out2 = out2_r;
    assign sample_out3 = out3_r;
endmodule

// File: tb/tb_adsr_envelope.sv
// Directed table-driven bench for adsr_envelope: each record sets the CVs, runs a
// number of sample ticks and compares all four outputs against hand-computed values.
module tb_adsr_envelope;
    logic clk = 1'b0;
    logic rst, sample_clk;
    logic signed [15:0] in0, in1, in2, in3;
    logic signed [15:0] out0, out1, out2, out3;
    logic [7:0] jack;
    int total = 0;
    int passed = 0;

    typedef struct {
        logic signed [15:0] in0, in1, in2, in3;
        int ticks;
        logic signed [15:0] e0, e2, e3;
    } vec_t;
    vec_t vecs[25];

    adsr_envelope dut (
        .clk(clk), .rst(rst), .sample_clk(sample_clk),
        .sample_in0(in0), .sample_in1(in1), .sample_in2(in2), .sample_in3(in3),
        .sample_out0(out0), .sample_out1(out1), .sample_out2(out2), .sample_out3(out3),
        .jack(jack)
    );

    always #5 clk = ~clk;

    task automatic set_vec(input int i, input int a, input int b, input int c, input int d,
                           input int n, input int e0, input int e2, input int e3);
        vecs[i].in0 = 16'(a); vecs[i].in1 = 16'(b); vecs[i].in2 = 16'(c); vecs[i].in3 = 16'(d);
        vecs[i].ticks = n;
        vecs[i].e0 = 16'(e0); vecs[i].e2 = 16'(e2); vecs[i].e3 = 16'(e3);
    endtask

    task automatic chk(input string nm, input int idx, input logic signed [15:0] act,
                       input logic signed [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
    endtask

    task automatic check_all(input int idx, input int e0, input int e2, input int e3);
        chk("out0", idx, out0, 16'(e0));
        chk("out1", idx, out1, 16'(-e0));
        chk("out2", idx, out2, 16'(e2));
        chk("out3", idx, out3, 16'(e3));
    endtask

    task automatic do_tick();
        sample_clk = 1'b1;
        @(posedge clk); #1;
        sample_clk = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        // in0, in1, in2, in3, ticks, out0, out2, out3
        set_vec( 0,    0, 32767, 32767, 16384,   3,     0,     0,     0);
        set_vec( 1, 3999, 32767, 32767, 16384,   2,     0,     0,     0);
        set_vec( 2, 4000, 32767, 32767, 16384,   2,     0,     0,     0);
        set_vec( 3, 8000, 32767, 32767, 16384,   1,     0, 20000,     0);
        set_vec( 4, 8000, 32767, 32767, 16384, 255, 32640, 20000,     0);
        set_vec( 5, 8000, 32767, 32767, 16384,   1, 32767, 20000,     0);
        set_vec( 6, 8000, 32767, 32767, 16384, 127, 16511, 20000,     0);
        set_vec( 7, 8000, 32767, 32767, 16384,   1, 16384, 20000,     0);
        set_vec( 8, 8000, 32767, 32767, 16384,   5, 16384, 20000,     0);
        set_vec( 9, 8000, 32767, 32767,  8192,   1,  8192, 20000,     0);
        set_vec(10, 3000, 32767, 32767,  8192,   3,  8192, 20000,     0);
        set_vec(11, 1999, 32767, 32767,  8192,   1,  8192,     0,     0);
        set_vec(12, 1999, 32767, 32767,  8192,  63,   128,     0,     0);
        set_vec(13, 1999, 32767, 32767,  8192,   1,     0,     0, 20000);
        set_vec(14, 1999, 32767, 32767,  8192,   7,     0,     0, 20000);
        set_vec(15, 1999, 32767, 32767,  8192,   1,     0,     0,     0);
        set_vec(16, 8000, -5000, 32767,  8192,   1,     0, 20000,     0);
        set_vec(17, 8000, -5000, 32767,  8192, 767,     2, 20000,     0);
        set_vec(18, 8000, -5000, 32767,  8192, 233,     3, 20000,     0);
        set_vec(19, 8000, 32767, 32767,  8192, 256, 32767, 20000,     0);
        set_vec(20,    0, 32767, 32767,  8192,   1, 32767,     0,     0);
        set_vec(21,    0, 32767, 32767,  8192, 178,  9983,     0,     0);
        set_vec(22, 8000, -5000, 32767,  8192,   1,  9983, 20000,     0);
        set_vec(23, 8000, -5000, 32767,  8192,   1,  9984, 20000,     0);
        set_vec(24, 8000, 32767, 32767,  8192,  10, 11264, 20000,     0);

        rst = 1'b1; sample_clk = 1'b0; jack = 8'h00;
        in0 = 16'sd0; in1 = 16'sd0; in2 = 16'sd0; in3 = 16'sd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_all(-1, 0, 0, 0);

        for (int i = 0; i < 25; i++) begin
            in0 = vecs[i].in0; in1 = vecs[i].in1; in2 = vecs[i].in2; in3 = vecs[i].in3;
            for (int t = 0; t < vecs[i].ticks; t++) do_tick();
            check_all(i, int'(vecs[i].e0), int'(vecs[i].e2), int'(vecs[i].e3));
        end

        // Reset mid-attack: outputs clear on the very next clock and gate stays low.
        in0 = 16'sd0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_all(100, 0, 0, 0);
        for (int t = 0; t < 3; t++) do_tick();
        check_all(101, 0, 0, 0);

        // Retrigger after reset starts from zero, proving no accumulator residue.
        in0 = 16'sd8000; in1 = 16'sd32767;
        do_tick();
        do_tick();
        check_all(102, 128, 20000, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
